// File: rtl/lcd_text_driver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_driver
// Brief    : Buffered text controller for HD44780 panels in 4-bit mode, with
//            autonomous init, continuous refresh, hardware clear and status.
//            Optional character readback is enabled by LCD_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_text_driver #(
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int INIT_WAIT = 750000,
    parameter int E_CYC     = 12,
    parameter int CMD_CYC   = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] in_bus,
    output logic [15:0] out_bus,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [3:0]  lcd_d
);

    localparam int C_DEPTH    = COLS * ROWS;
    localparam int C_AW       = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int C_CLR_WAIT = 40 * CMD_CYC;
    localparam int C_MAXW     = (INIT_WAIT > C_CLR_WAIT) ?
                                ((INIT_WAIT > E_CYC) ? INIT_WAIT : E_CYC) :
                                ((C_CLR_WAIT > E_CYC) ? C_CLR_WAIT : E_CYC);
    localparam int C_CW       = $clog2(C_MAXW + 2) + 1;

    localparam logic [C_CW-1:0] c_init_wait = C_CW'(INIT_WAIT);
    localparam logic [C_CW-1:0] c_e_cyc     = C_CW'(E_CYC);
    localparam logic [C_CW-1:0] c_cmd_wait  = C_CW'(CMD_CYC);
    localparam logic [C_CW-1:0] c_clr_wait  = C_CW'(C_CLR_WAIT);
    localparam logic [6:0]      c_depth_idx = 7'(C_DEPTH);
    localparam logic [C_AW-1:0] c_last_idx  = C_AW'(C_DEPTH - 1);
    localparam logic [4:0]      c_last_col  = 5'(COLS - 1);
    localparam logic [1:0]      c_last_row  = 2'(ROWS - 1);

    // Sequencer phases
    localparam logic [2:0] c_seq_power_wait = 3'd0;
    localparam logic [2:0] c_seq_init       = 3'd1;
    localparam logic [2:0] c_seq_config     = 3'd2;
    localparam logic [2:0] c_seq_set_addr   = 3'd3;
    localparam logic [2:0] c_seq_chars      = 3'd4;

    // Nibble engine states
    localparam logic [2:0] c_eng_idle  = 3'd0;
    localparam logic [2:0] c_eng_setup = 3'd1;
    localparam logic [2:0] c_eng_high  = 3'd2;
    localparam logic [2:0] c_eng_hold  = 3'd3;
    localparam logic [2:0] c_eng_wait  = 3'd4;

    function automatic logic [6:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    row_base = 7'h00;
            2'd1:    row_base = 7'h40;
            2'd2:    row_base = 7'h14;
            default: row_base = 7'h54;
        endcase
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [1:0] s);
        case (s)
            2'd0:    cfg_byte = 8'h28;
            2'd1:    cfg_byte = 8'h0C;
            2'd2:    cfg_byte = 8'h06;
            default: cfg_byte = 8'h01;
        endcase
    endfunction

    logic [7:0]      buf_mem [C_DEPTH];

    logic [2:0]      seq_q, seq_d;
    logic [2:0]      eng_q, eng_d;
    logic [C_CW-1:0] cnt_q, cnt_d;
    logic [C_CW-1:0] wait_len_q, wait_len_d;
    logic [1:0]      step_q, step_d;
    logic [1:0]      row_q, row_d;
    logic [4:0]      col_q, col_d;
    logic [C_AW-1:0] ptr_q, ptr_d;
    logic [3:0]      lo_nib_q, lo_nib_d;
    logic            single_q, single_d;
    logic            low_q, low_d;
    logic            ready_q, ready_d;
    logic [7:0]      frame_q, frame_d;
    logic            clearing_q, clearing_d;
    logic [C_AW-1:0] clr_idx_q, clr_idx_d;
    logic [15:0]     out_bus_q, out_bus_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic            lcd_e_q, lcd_e_d;
    logic [3:0]      lcd_d_q, lcd_d_d;

    logic [C_CW-1:0] cnt_inc;
    logic            launch;
    logic [7:0]      launch_byte;
    logic            launch_rs;
    logic            launch_single;

    logic [6:0]      idx;
    logic            idx_ok;
    logic            acc_char;
    logic            acc_clear;
    logic            mem_we;
    logic [C_AW-1:0] mem_addr;
    logic [7:0]      mem_wdata;
    logic [15:0]     status_word;

    assign status_word = {ready_q, clearing_q, 6'b0, frame_q};
    assign idx         = in_bus[14:8];
    assign idx_ok      = (idx < c_depth_idx);
    assign acc_char    = write && !clearing_q && !in_bus[15] && idx_ok;
    assign acc_clear   = write && !clearing_q &&  in_bus[15] && in_bus[0];

    // Bus side: character store, hardware clear and read data
    always_comb begin
        clearing_d = clearing_q;
        clr_idx_d  = clr_idx_q;
        mem_we     = 1'b0;
        mem_addr   = in_bus[8 +: C_AW];
        mem_wdata  = in_bus[7:0];
        out_bus_d  = out_bus_q;

        if (clearing_q) begin
            mem_we    = !rst;
            mem_addr  = clr_idx_q;
            mem_wdata = 8'h20;
            if (clr_idx_q == c_last_idx) begin
                clearing_d = 1'b0;
            end else begin
                clr_idx_d = clr_idx_q + C_AW'(1);
            end
        end else if (acc_clear) begin
            clearing_d = 1'b1;
            clr_idx_d  = '0;
        end else if (acc_char) begin
            mem_we = !rst;
        end

        if (read) begin
`ifdef LCD_READBACK_EN
            if (in_bus[15]) begin
                out_bus_d = status_word;
            end else if (idx_ok) begin
                out_bus_d = {8'h00, buf_mem[in_bus[8 +: C_AW]]};
            end else begin
                out_bus_d = 16'h0000;
            end
`else
            out_bus_d = status_word;
`endif
        end
    end

    always_comb begin
        cnt_inc       = cnt_q + C_CW'(1);
        seq_d         = seq_q;
        eng_d         = eng_q;
        cnt_d         = cnt_q;
        wait_len_d    = wait_len_q;
        step_d        = step_q;
        row_d         = row_q;
        col_d         = col_q;
        ptr_d         = ptr_q;
        lo_nib_d      = lo_nib_q;
        single_d      = single_q;
        low_d         = low_q;
        ready_d       = ready_q;
        frame_d       = frame_q;
        lcd_rs_d      = lcd_rs_q;
        lcd_e_d       = lcd_e_q;
        lcd_d_d       = lcd_d_q;
        launch        = 1'b0;
        launch_byte   = 8'h00;
        launch_rs     = 1'b0;
        launch_single = 1'b0;

        case (eng_q)
            c_eng_idle: begin
                if (cnt_inc >= c_init_wait) begin
                    launch        = 1'b1;
                    launch_single = 1'b1;
                    launch_byte   = 8'h03;
                    seq_d         = c_seq_init;
                    step_d        = 2'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            c_eng_setup: begin
                if (cnt_inc >= c_e_cyc) begin
                    eng_d   = c_eng_high;
                    cnt_d   = '0;
                    lcd_e_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            c_eng_high: begin
                if (cnt_inc >= c_e_cyc) begin
                    eng_d   = c_eng_hold;
                    cnt_d   = '0;
                    lcd_e_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            c_eng_hold: begin
                if (cnt_inc >= c_e_cyc) begin
                    cnt_d = '0;
                    if (single_q || low_q) begin
                        eng_d = c_eng_wait;
                    end else begin
                        low_d   = 1'b1;
                        lcd_d_d = lo_nib_q;
                        eng_d   = c_eng_setup;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            c_eng_wait: begin
                if (cnt_inc >= wait_len_q) begin
                    case (seq_q)
                        c_seq_init: begin
                            launch = 1'b1;
                            if (step_q != 2'd3) begin
                                step_d        = step_q + 2'd1;
                                launch_single = 1'b1;
                                launch_byte   = (step_q == 2'd2) ? 8'h02 : 8'h03;
                            end else begin
                                seq_d       = c_seq_config;
                                step_d      = 2'd0;
                                launch_byte = cfg_byte(2'd0);
                            end
                        end
                        c_seq_config: begin
                            launch = 1'b1;
                            if (step_q != 2'd3) begin
                                step_d      = step_q + 2'd1;
                                launch_byte = cfg_byte(step_q + 2'd1);
                            end else begin
                                ready_d     = 1'b1;
                                seq_d       = c_seq_set_addr;
                                row_d       = 2'd0;
                                launch_byte = {1'b1, row_base(2'd0)};
                            end
                        end
                        c_seq_set_addr: begin
                            launch      = 1'b1;
                            launch_rs   = 1'b1;
                            launch_byte = buf_mem[ptr_q];
                            ptr_d       = ptr_q + C_AW'(1);
                            col_d       = 5'd0;
                            seq_d       = c_seq_chars;
                        end
                        c_seq_chars: begin
                            launch = 1'b1;
                            if (col_q != c_last_col) begin
                                col_d       = col_q + 5'd1;
                                launch_rs   = 1'b1;
                                launch_byte = buf_mem[ptr_q];
                                ptr_d       = ptr_q + C_AW'(1);
                            end else if (row_q != c_last_row) begin
                                row_d       = row_q + 2'd1;
                                seq_d       = c_seq_set_addr;
                                launch_byte = {1'b1, row_base(row_q + 2'd1)};
                            end else begin
                                frame_d     = frame_q + 8'd1;
                                row_d       = 2'd0;
                                ptr_d       = '0;
                                seq_d       = c_seq_set_addr;
                                launch_byte = {1'b1, row_base(2'd0)};
                            end
                        end
                        default: begin
                            seq_d = c_seq_power_wait;
                            eng_d = c_eng_idle;
                            cnt_d = '0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                eng_d = c_eng_idle;
                cnt_d = '0;
            end
        endcase

        // Single nibbles go out as-is; bytes start with the high nibble
        if (launch) begin
            eng_d    = c_eng_setup;
            cnt_d    = '0;
            lcd_rs_d = launch_rs;
            single_d = launch_single;
            low_d    = 1'b0;
            lo_nib_d = launch_byte[3:0];
            lcd_d_d  = launch_single ? launch_byte[3:0] : launch_byte[7:4];
            wait_len_d = (!launch_rs && !launch_single && launch_byte == 8'h01) ?
                         c_clr_wait : c_cmd_wait;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            buf_mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q      <= c_seq_power_wait;
            eng_q      <= c_eng_idle;
            cnt_q      <= '0;
            wait_len_q <= '0;
            step_q     <= 2'd0;
            row_q      <= 2'd0;
            col_q      <= 5'd0;
            ptr_q      <= '0;
            lo_nib_q   <= 4'h0;
            single_q   <= 1'b0;
            low_q      <= 1'b0;
            ready_q    <= 1'b0;
            frame_q    <= 8'h00;
            clearing_q <= 1'b1;
            clr_idx_q  <= '0;
            out_bus_q  <= 16'h0000;
            lcd_rs_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_d_q    <= 4'h0;
        end else begin
            seq_q      <= seq_d;
            eng_q      <= eng_d;
            cnt_q      <= cnt_d;
            wait_len_q <= wait_len_d;
            step_q     <= step_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ptr_q      <= ptr_d;
            lo_nib_q   <= lo_nib_d;
            single_q   <= single_d;
            low_q      <= low_d;
            ready_q    <= ready_d;
            frame_q    <= frame_d;
            clearing_q <= clearing_d;
            clr_idx_q  <= clr_idx_d;
            out_bus_q  <= out_bus_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_e_q    <= lcd_e_d;
            lcd_d_q    <= lcd_d_d;
        end
    end

    assign out_bus = out_bus_q;
    assign lcd_rs  = lcd_rs_q;
    assign lcd_rw  = 1'b0;
    assign lcd_e   = lcd_e_q;
    assign lcd_d   = lcd_d_q;

endmodule
`default_nettype wire
